// File: rtl/apb_regfile_slave.sv
// APB3/APB4 completer exposing NUM_REGS read/write words plus a read-only STATUS
// word (write-commit count in [15:0], saturating error count in [31:16]).
module apb_regfile_slave #(
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  // state  | meaning
  // IDLE   | waiting for a setup phase (psel=1, penable=0)
  // ACCESS | access phase; wait states while cnt>0, completes at cnt=0
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [5:0] STATUS_IDX = 6'(NUM_REGS);
  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] regs [NUM_REGS];
  logic [15:0] wr_cnt, err_cnt;
  logic [5:0]  idx;
  logic        is_reg, is_status;
  logic        complete, err, wr_commit;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  assign idx              = paddr[7:2];
  assign is_reg           = idx < STATUS_IDX;
  assign is_status        = idx == STATUS_IDX;
  assign unused_addr_bits = ^paddr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Dropping psel mid-access abandons the transfer and leaves cnt untouched.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          state_next = ACCESS;
          cnt_next   = WAIT_LOAD;
        end
      end
      ACCESS: begin
        if (!psel)
          state_next = IDLE;
        else if (cnt != 4'd0)
          cnt_next = cnt - 4'd1;
        else if (penable)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (is_status)
      rd_data = {err_cnt, wr_cnt};
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == 6'(i))
        rd_data = regs[i];
    complete  = (state == ACCESS) && (cnt == 4'd0) && psel && penable;
    err       = complete && (!(is_reg || is_status) || (pwrite && is_status));
    wr_commit = complete && pwrite && !err;
    pready    = complete;
    pslverr   = err;
    prdata    = (complete && !pwrite && !err) ? rd_data : '0;
  end

  // STATUS reads see the counters as they stood before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (wr_commit) begin
        wr_cnt <= wr_cnt + 16'd1;
        for (int i = 0; i < NUM_REGS; i++)
          if (idx == 6'(i))
            for (int b = 0; b < 4; b++)
              if (pstrb[b])
                regs[i][8*b +: 8] <= pwdata[8*b +: 8];
      end
      if (err && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: three instances (one with a wait state, two
// zero-wait) driven by a linear sequence; expected completions are queued then popped.
module tb_apb_regfile_slave;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst     [3];
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [7:0]  paddr   [3];
  logic [31:0] pwdata  [3];
  logic [3:0]  pstrb   [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   setup_cyc = 0;
  int   done_cyc = 0;
  int   first_setup = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_regfile_slave #(.NUM_REGS(8), .WAIT_CYCLES(g == 0 ? 1 : 0)) dut (
      .clk(clk), .reset(rst[g]), .psel(psel[g]), .penable(penable[g]),
      .pwrite(pwrite[g]), .paddr(paddr[g]), .pwdata(pwdata[g]), .pstrb(pstrb[g]),
      .prdata(prdata[g]), .pready(pready[g]), .pslverr(pslverr[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int g, input string tag, input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp_rd,
                      input logic exp_err, input int exp_acc, input bit do_chk);
    exp_t e;
    int   n;
    if (do_chk) sb.push_back('{rd: exp_rd, err: exp_err, acc: exp_acc});
    @(posedge clk); #1;
    psel[g] = 1'b1; penable[g] = 1'b0; pwrite[g] = wr;
    paddr[g] = a; pwdata[g] = d; pstrb[g] = s;
    setup_cyc = cyc;
    @(posedge clk); #1;
    penable[g] = 1'b1;
    #1;
    n = 1;
    while (pready[g] !== 1'b1 && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    done_cyc = cyc;
    if (do_chk) begin
      e = sb.pop_front();
      check({tag, "_pready"}, 32'(pready[g]), 32'd1);
      check({tag, "_prdata"}, prdata[g], e.rd);
      check({tag, "_pslverr"}, 32'(pslverr[g]), 32'(e.err));
      check({tag, "_acc_cycles"}, 32'(n), 32'(e.acc));
    end
  endtask

  task automatic idle(input int g);
    @(posedge clk); #1;
    psel[g] = 1'b0; penable[g] = 1'b0;
  endtask

  task automatic rst_pulse(input int g);
    @(posedge clk); #1;
    psel[g] = 1'b0; penable[g] = 1'b0; rst[g] = 1'b1;
    @(posedge clk); #1;
    rst[g] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; psel[g] = 1'b0; penable[g] = 1'b0; pwrite[g] = 1'b0;
      paddr[g] = '0; pwdata[g] = '0; pstrb[g] = '0;
    end
    #1;
    for (int g = 0; g < 3; g++) begin
      check("reset_pready", 32'(pready[g]), 32'd0);
      check("reset_pslverr", 32'(pslverr[g]), 32'd0);
      check("reset_prdata", prdata[g], 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;

    // Instance 0: one wait state
    xfer(0, "rd_reg0_after_reset", 0, 8'h00, 0, 4'h0, 32'h0, 0, 2, 1);
    xfer(0, "wr_deadbeef", 1, 8'h04, 32'hDEADBEEF, 4'hF, 32'h0, 0, 2, 1);
    xfer(0, "rd_deadbeef", 0, 8'h04, 0, 4'h0, 32'hDEADBEEF, 0, 2, 1);
    xfer(0, "rd_status_1", 0, 8'h20, 0, 4'h0, 32'h00000001, 0, 2, 1);
    xfer(0, "wr_strb5", 1, 8'h00, 32'h11223344, 4'h5, 32'h0, 0, 2, 1);
    xfer(0, "rd_strb5", 0, 8'h00, 0, 4'h0, 32'h00220044, 0, 2, 1);
    xfer(0, "rd_unmapped_24", 0, 8'h24, 0, 4'h0, 32'h0, 1, 2, 1);
    xfer(0, "wr_status", 1, 8'h20, 32'hAAAAAAAA, 4'hF, 32'h0, 1, 2, 1);
    xfer(0, "rd_status_2_2", 0, 8'h20, 0, 4'h0, 32'h00020002, 0, 2, 1);
    xfer(0, "rd_reg1_kept", 0, 8'h04, 0, 4'h0, 32'hDEADBEEF, 0, 2, 1);
    xfer(0, "rd_low_bits_ignored", 0, 8'h07, 0, 4'h0, 32'hDEADBEEF, 0, 2, 1);
    xfer(0, "wr_strb0", 1, 8'h04, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 2, 1);
    xfer(0, "rd_after_strb0", 0, 8'h04, 0, 4'h0, 32'hDEADBEEF, 0, 2, 1);
    xfer(0, "rd_unmapped_fc", 0, 8'hFC, 0, 4'h0, 32'h0, 1, 2, 1);
    xfer(0, "rd_status_3_3", 0, 8'h20, 0, 4'h0, 32'h00030003, 0, 2, 1);

    // psel+penable without a setup phase is ignored
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 8'h00; pwdata[0] = 32'hFFFFFFFF; pstrb[0] = 4'hF;
    #1 check("no_setup_pready_a", 32'(pready[0]), 32'd0);
    repeat (2) @(posedge clk);
    #2 check("no_setup_pready_b", 32'(pready[0]), 32'd0);
    idle(0);
    xfer(0, "rd_after_no_setup", 0, 8'h00, 0, 4'h0, 32'h00220044, 0, 2, 1);

    // Abort: psel drops during the access phase
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 8'h0C; pwdata[0] = 32'h55AA55AA; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    #1 check("abort_wait_pready", 32'(pready[0]), 32'd0);
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    #1 check("abort_pready", 32'(pready[0]), 32'd0);
    xfer(0, "rd_after_abort", 0, 8'h0C, 0, 4'h0, 32'h0, 0, 2, 1);
    xfer(0, "rd_status_abort", 0, 8'h20, 0, 4'h0, 32'h00030003, 0, 2, 1);

    // Reset during a wait state of a write to 0x08
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 8'h08; pwdata[0] = 32'hCAFEF00D; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    #1 check("rst_wait_pready", 32'(pready[0]), 32'd0);
    rst[0] = 1'b1;
    #1;
    check("rst_mid_pready", 32'(pready[0]), 32'd0);
    check("rst_mid_pslverr", 32'(pslverr[0]), 32'd0);
    check("rst_mid_prdata", prdata[0], 32'd0);
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0; rst[0] = 1'b0;
    xfer(0, "rd_reg2_after_rst", 0, 8'h08, 0, 4'h0, 32'h0, 0, 2, 1);
    xfer(0, "rd_status_after_rst", 0, 8'h20, 0, 4'h0, 32'h0, 0, 2, 1);
    xfer(0, "rd_reg1_after_rst", 0, 8'h04, 0, 4'h0, 32'h0, 0, 2, 1);
    xfer(0, "wr_reg2_post_rst", 1, 8'h08, 32'h12345678, 4'hF, 32'h0, 0, 2, 1);
    xfer(0, "rd_reg2_post_rst", 0, 8'h08, 0, 4'h0, 32'h12345678, 0, 2, 1);
    xfer(0, "rd_status_post_rst", 0, 8'h20, 0, 4'h0, 32'h00000001, 0, 2, 1);
    idle(0);

    // Instance 1: zero-wait back-to-back writes
    xfer(1, "b2b_wr0", 1, 8'h00, 32'h00000011, 4'hF, 32'h0, 0, 1, 1);
    first_setup = setup_cyc;
    xfer(1, "b2b_wr1", 1, 8'h04, 32'h00000022, 4'hF, 32'h0, 0, 1, 1);
    xfer(1, "b2b_wr2", 1, 8'h08, 32'h00000033, 4'hF, 32'h0, 0, 1, 1);
    check("b2b_total_cycles", 32'(done_cyc - first_setup), 32'd5);
    xfer(1, "b2b_status", 0, 8'h20, 0, 4'h0, 32'h00000003, 0, 1, 1);
    xfer(1, "b2b_rd1", 0, 8'h04, 0, 4'h0, 32'h00000022, 0, 1, 1);
    rst_pulse(1);

    // Counter stress: write-count wrap on instance 1, error saturation on instance 2
    fork
      begin
        for (int i = 0; i < 65535; i++)
          xfer(1, "stress_wr", 1, 8'h04, 32'(i), 4'hF, 32'h0, 0, 1, 0);
      end
      begin
        for (int i = 0; i < 65537; i++)
          xfer(2, "stress_err", i[0], (i[0] ? 8'h20 : 8'hF0), 32'(i), 4'hF, 32'h0, 1, 1, 0);
      end
    join
    xfer(1, "wr_cnt_ffff", 0, 8'h20, 0, 4'h0, 32'h0000FFFF, 0, 1, 1);
    xfer(1, "stress_last_data", 0, 8'h04, 0, 4'h0, 32'h0000FFFE, 0, 1, 1);
    xfer(1, "wr_wrap", 1, 8'h04, 32'hA5A5A5A5, 4'hF, 32'h0, 0, 1, 1);
    xfer(1, "wr_cnt_wrapped", 0, 8'h20, 0, 4'h0, 32'h00000000, 0, 1, 1);
    xfer(1, "rd_after_wrap", 0, 8'h04, 0, 4'h0, 32'hA5A5A5A5, 0, 1, 1);
    xfer(2, "err_cnt_sat", 0, 8'h20, 0, 4'h0, 32'hFFFF0000, 0, 1, 1);
    xfer(2, "err_one_more", 0, 8'h28, 0, 4'h0, 32'h0, 1, 1, 1);
    xfer(2, "err_cnt_still_sat", 0, 8'h20, 0, 4'h0, 32'hFFFF0000, 0, 1, 1);
    xfer(2, "err_reg0_untouched", 0, 8'h00, 0, 4'h0, 32'h0, 0, 1, 1);
    idle(1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
